// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the datapath controller and the ALU.
// Latency: n/a (wiring only).
// Backpressure: controller holds start while busy is high.
interface multicycle_alu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       alucontrol;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             busy;
    logic             done;
    logic             illegal;

    // Controller side: issues operations, observes completion.
    modport master (
        output start, alucontrol, a, b,
        input  result, zero, busy, done, illegal
    );

    // ALU side.
    modport slave (
        input  start, alucontrol, a, b,
        output result, zero, busy, done, illegal
    );
endinterface

// File: rtl/multicycle_alu.sv
// ALU with one-cycle logic/arith ops, shift-add multiply, restoring signed divide.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 for mul, WIDTH+2 for div (start edge to done).
// Backpressure: start is ignored while busy; requester must hold it until busy drops.
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    multicycle_alu_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b1010;
    localparam logic [3:0] OP_SLT = 4'b1011;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DFIX} state_t;

    state_t           state, next_state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, done_q, illegal_q;

    // Multiplier working registers.
    logic [WIDTH-1:0] acc, mcand, mplier;
    // Divider working registers: partial remainder, quotient/dividend shift reg, |divisor|.
    logic [WIDTH-1:0] rem, quo, dvsr;
    logic             qsign, div_zero;

    logic             accept, last_iter, finish, fin_illegal;
    logic [WIDTH-1:0] fin_result, acc_step;
    logic [WIDTH:0]   rem_sh, diff;

    assign accept    = bus.start && (state == IDLE);
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign acc_step  = mplier[0] ? (acc + mcand) : acc;
    // One extra bit so the trial subtraction's borrow shows the restore decision.
    assign rem_sh    = {rem, quo[WIDTH-1]};
    assign diff      = rem_sh - {1'b0, dvsr};

    // State register; reset aborts any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and completion decode.
    always_comb begin
        next_state  = state;
        finish      = 1'b0;
        fin_illegal = 1'b0;
        fin_result  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    finish = 1'b1;
                    case (bus.alucontrol)
                        OP_ADD: fin_result = bus.a + bus.b;
                        OP_SUB: fin_result = bus.a - bus.b;
                        OP_SLT: fin_result = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
                        OP_AND: fin_result = bus.a & bus.b;
                        OP_OR:  fin_result = bus.a | bus.b;
                        OP_MUL: begin
                            finish     = 1'b0;
                            next_state = MUL;
                        end
                        OP_DIV: begin
                            finish     = 1'b0;
                            next_state = DIV;
                        end
                        default: fin_illegal = 1'b1;
                    endcase
                end
            end
            MUL: begin
                if (last_iter) begin
                    next_state = IDLE;
                    finish     = 1'b1;
                    fin_result = acc_step;
                end
            end
            DIV: begin
                if (last_iter) next_state = DFIX;
            end
            DFIX: begin
                next_state = IDLE;
                finish     = 1'b1;
                // Divide-by-zero forced to all ones regardless of dividend sign.
                if (div_zero)   fin_result = '1;
                else if (qsign) fin_result = -quo;
                else            fin_result = quo;
            end
            default: next_state = IDLE;
        endcase
    end

    // Completion outputs: updated only on a finishing edge, done pulses for one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= finish;
            if (finish) begin
                result_q  <= fin_result;
                zero_q    <= (fin_result == '0);
                illegal_q <= fin_illegal;
            end
        end
    end

    // Iterative datapath: operand capture on accept, one mul/div step per busy edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
            qsign    <= 1'b0;
            div_zero <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            acc      <= '0;
            mcand    <= bus.a;
            mplier   <= bus.b;
            rem      <= '0;
            quo      <= bus.a[WIDTH-1] ? -bus.a : bus.a;
            dvsr     <= bus.b[WIDTH-1] ? -bus.b : bus.b;
            qsign    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            div_zero <= (bus.b == '0);
        end else if (state == MUL) begin
            acc    <= acc_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
        end else if (state == DIV) begin
            if (!diff[WIDTH]) begin
                rem <= diff[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
            end else begin
                rem <= rem_sh[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + CW'(1);
        end
    end

    assign bus.result  = result_q;
    assign bus.zero    = zero_q;
    assign bus.done    = done_q;
    assign bus.illegal = illegal_q;
    assign bus.busy    = (state != IDLE);
endmodule
